// File: rtl/seg7_mmio_conv_pkg.sv
// Shared constants, FSM encoding and the byte-merge helper for the 7-seg MMIO front end.
package seg7_pkg;
  localparam logic        ADDR_DATA   = 1'b0;
  localparam logic        ADDR_CTRL   = 1'b1;
  localparam logic        MODE_HEX    = 1'b0;
  localparam logic        MODE_DEC    = 1'b1;
  localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;
  localparam int          BUS_W       = 32;
  localparam int          BE_W        = BUS_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [BUS_W-1:0] merge_bytes(input logic [BUS_W-1:0] old_val,
                                                   input logic [BUS_W-1:0] new_val,
                                                   input logic [BE_W-1:0]  be);
    logic [BUS_W-1:0] res;
    res = old_val;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/seg7_mmio_conv_if.sv
// CPU bus view of the display front end: write strobe/address/byte enables/data and registered read data.
interface seg7_mmio_conv_if;
  import seg7_pkg::*;
  logic                we;
  logic                addr;
  logic [BE_W-1:0]     be;
  logic [BUS_W-1:0]    wdata;
  logic [BUS_W-1:0]    rdata;

  modport master (output we, output addr, output be, output wdata, input  rdata);
  modport slave  (input  we, input  addr, input  be, input  wdata, output rdata);
endinterface

// File: rtl/seg7_mmio_conv_bcd_add3_stage.sv
// One double-dabble correction step: every BCD digit >= 5 gets +3 before the next left shift.
module bcd_add3_stage #(
  parameter int DIGITS = 10
) (
  input  logic [DIGITS*4-1:0] bcd_in,
  output logic [DIGITS*4-1:0] bcd_out
);
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign bcd_out[4*g +: 4] = (bcd_in[4*g +: 4] >= 4'd5) ? bcd_in[4*g +: 4] + 4'd3
                                                          : bcd_in[4*g +: 4];
  end
endmodule

// File: rtl/seg7_mmio_conv.sv
// Memory-mapped DATA/CTRL registers feeding the 7-seg scanner; HEX passthrough or
// iterative binary-to-BCD conversion (one bit per clock) in DEC mode.
module seg7_mmio_conv
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  seg7_mmio_conv_if.slave   bus,
  output logic              busy,
  output logic [31:0]       displayData
);
  localparam int CNT_W = $clog2(BIN_W);
  localparam int BCD_W = DIGITS * 4;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   data_q,  data_d;
  logic               mode_q,  mode_d;
  logic               ovf_q,   ovf_d;
  logic               busy_q,  busy_d;
  logic [31:0]        disp_q,  disp_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BUS_W-1:0]   rdata_d;

  logic [BCD_W-1:0]       corr;
  logic [BCD_W+BIN_W-1:0] sh;
  logic                   wr_data, wr_ctrl, trigger;

  bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
    .bcd_in  (bcd_q),
    .bcd_out (corr)
  );

  // Corrected BCD and the remaining binary shift as one register pair.
  assign sh = {corr, shift_q} << 1;

  assign wr_data = bus.we && (bus.addr == ADDR_DATA);
  assign wr_ctrl = bus.we && (bus.addr == ADDR_CTRL);

  always_comb begin
    data_d  = data_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    trigger = 1'b0;

    if (wr_data) data_d = merge_bytes(data_q, bus.wdata, bus.be);
    if (wr_ctrl) mode_d = bus.wdata[0];

    // A mode re-write to DEC is not a trigger; only a HEX->DEC change or new data is.
    trigger = (mode_d == MODE_DEC) && (wr_data || (wr_ctrl && mode_q == MODE_HEX));

    if (mode_d == MODE_HEX) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      ovf_d   = 1'b0;
      disp_d  = data_d;
    end else if (trigger) begin
      shift_d = data_d;
      bcd_d   = '0;
      cnt_d   = '0;
      state_d = ST_CONV;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_CONV: begin
          bcd_d   = sh[BCD_W+BIN_W-1:BIN_W];
          shift_d = sh[BIN_W-1:0];
          if (cnt_q == CNT_W'(BIN_W-1)) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (|bcd_q[BCD_W-1:32]) begin
            ovf_d  = 1'b1;
            disp_d = OVF_PATTERN;
          end else begin
            ovf_d  = 1'b0;
            disp_d = bcd_q[31:0];
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read mux looks at register state before this edge's write.
  assign rdata_d = (bus.addr == ADDR_CTRL) ? {{(BUS_W-3){1'b0}}, busy_q, ovf_q, mode_q}
                                           : data_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      mode_q    <= MODE_HEX;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      disp_q    <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      bus.rdata <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      disp_q    <= disp_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      bus.rdata <= rdata_d;
    end
  end

  assign busy        = busy_q;
  assign displayData = disp_q;
endmodule

// File: tb/tb_seg7_mmio_conv.sv
// Randomized bench for seg7_mmio_conv with a decimal-arithmetic reference model and directed literal checks.
module tb_seg7_mmio_conv;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        busy;
  logic [31:0] displayData;

  seg7_mmio_conv_if bus();

  seg7_mmio_conv dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .busy        (busy),
    .displayData (displayData)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, overflow when the value needs more than 8 digits.
  function automatic void dec_of(input logic [31:0] v, output logic [31:0] d, output logic o);
    longint x;
    x = longint'(v);
    d = '0;
    o = 1'b0;
    if (x >= 64'd100000000) begin
      d = 32'hEEEE_EEEE;
      o = 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        d[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  // Model state: registers plus a countdown to when the pending decimal result appears.
  logic [31:0] m_data, m_disp, m_rdata, m_target;
  logic        m_mode, m_ovf, m_busy;
  int          m_left;

  initial begin
    logic old_mode;
    logic [31:0] res;
    logic        o;
    m_data = 0; m_disp = 0; m_rdata = 0; m_target = 0;
    m_mode = 0; m_ovf = 0; m_busy = 0; m_left = 0;
    forever begin
      @(posedge CLK);
      if (!RST_N) begin
        m_data = 0; m_disp = 0; m_rdata = 0; m_mode = 0; m_ovf = 0; m_busy = 0; m_left = 0;
        continue;
      end
      m_rdata = bus.addr ? {29'b0, m_busy, m_ovf, m_mode} : m_data;
      if (bus.we && !bus.addr)
        for (int i = 0; i < 4; i++)
          if (bus.be[i]) m_data[8*i +: 8] = bus.wdata[8*i +: 8];
      old_mode = m_mode;
      if (bus.we && bus.addr) m_mode = bus.wdata[0];
      if (!m_mode) begin
        m_disp = m_data; m_ovf = 0; m_busy = 0; m_left = 0;
      end else if (bus.we && (!bus.addr || !old_mode)) begin
        m_target = m_data; m_left = 33; m_busy = 1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          dec_of(m_target, res, o);
          m_disp = res; m_ovf = o; m_busy = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        chk("cyc_display", displayData, m_disp);
        chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
        chk("cyc_rdata", bus.rdata, m_rdata);
      end
    end
  end

  task automatic wr(input logic a, input logic [3:0] b, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.be = b; bus.wdata = d;
    @(negedge CLK); #1;
    bus.we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge CLK); #1;
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    bus.we = 1'b0; bus.addr = a;
    @(negedge CLK); #1;
    v = bus.rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, nb, n1;
    logic [31:0] v, val;
    logic [3:0]  b;
    bus.we = 0; bus.addr = 0; bus.be = 0; bus.wdata = 0;
    idle(3);
    chk("reset_display", displayData, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    RST_N = 1'b1;
    idle(2);

    // HEX passthrough
    wr(1'b0, 4'hF, 32'hDEAD_BEEF);
    chk("hex_display", displayData, 32'hDEAD_BEEF);
    chk("hex_busy", {31'b0, busy}, 32'h0);

    // DEC conversion
    wr(1'b1, 4'hF, 32'h1);
    wr(1'b0, 4'hF, 32'h00BC_614E);
    wait_idle(n);
    chk("dec_busy_cycles", n, 33);
    chk("dec_display", displayData, 32'h1234_5678);
    chk("model_dec", m_disp, 32'h1234_5678);
    rd(1'b1, v);
    chk("dec_ctrl", v, 32'h1);

    wr(1'b0, 4'hF, 32'h05F5_E0FF);
    wait_idle(n);
    chk("dec_max", displayData, 32'h9999_9999);
    wr(1'b0, 4'hF, 32'h05F5_E100);
    wait_idle(n);
    chk("dec_ovf", displayData, 32'hEEEE_EEEE);
    chk("model_ovf", m_disp, 32'hEEEE_EEEE);
    rd(1'b1, v);
    chk("dec_ovf_ctrl", v, 32'h3);
    wr(1'b0, 4'hF, 32'h0);
    wait_idle(n);
    chk("dec_zero", displayData, 32'h0);

    // Abort: second write 10 cycles after the first
    wr(1'b0, 4'hF, 32'h1);
    nb = busy ? 1 : 0;
    n1 = (displayData == 32'h1) ? 1 : 0;
    repeat (9) begin
      @(negedge CLK); #1;
      if (busy) nb++;
      if (displayData == 32'h1) n1++;
    end
    wr(1'b0, 4'hF, 32'hFF);
    wait_idle(n);
    chk("abort_busy_total", nb + n, 43);
    chk("abort_never_one", n1, 0);
    chk("abort_display", displayData, 32'h0000_0255);

    // Byte enables in HEX
    wr(1'b1, 4'hF, 32'h0);
    wr(1'b0, 4'hF, 32'h1122_3344);
    wr(1'b0, 4'b0010, 32'hAAAA_AAAA);
    chk("be_display", displayData, 32'h1122_AA44);
    rd(1'b0, v);
    chk("be_read", v, 32'h1122_AA44);

    // Reset mid-conversion
    wr(1'b1, 4'hF, 32'h1);
    idle(5);
    chk("pre_reset_busy", {31'b0, busy}, 32'h1);
    RST_N = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_display", displayData, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    idle(2);
    RST_N = 1'b1;
    rd(1'b1, v);
    chk("rst_mode", v, 32'h0);

    // Random traffic, checked every cycle by the model
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0: val = $urandom_range(0, 999);
        1: val = $urandom_range(32'h05F5_E0F0, 32'h05F5_E110);
        2: val = $urandom_range(0, 99_999_999);
        default: val = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 4) == 0)
        wr(1'b1, 4'($urandom), {31'b0, 1'($urandom)});
      else
        wr(1'b0, b, val);
      bus.addr = 1'($urandom);
      idle($urandom_range(0, 40));
    end
    bus.addr = 1'b0;
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
